// File: rtl/packet_framer_pkg.sv
// packet_framer_pkg: shared FSM states, CRC constants and hex encoding for the packet framer
package packet_framer_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC, TERM} state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Uppercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// crc16_ccitt_byte: one-byte CRC-16/CCITT-FALSE step, MSB first, no reflection
//   crc_in    running CRC before the byte
//   data_byte payload byte
//   crc_out   CRC after the byte
module crc16_ccitt_byte
    import packet_framer_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {data_byte, 8'h00};
        for (int i = 0; i < 8; i++)
            crc_out = crc_out[15] ? {crc_out[14:0], 1'b0} ^ CRC_POLY : {crc_out[14:0], 1'b0};
    end

endmodule

// File: rtl/packet_framer.sv
// packet_framer: double-buffered telemetry snapshot sent as a CRC-16 protected byte stream
//   sysclk/reset             clock, synchronous active-high reset
//   load, packet_in          capture request and packet (MSB sent first)
//   byte_out/valid/ready     byte stream toward the transmitter
//   busy                     frame in flight or shadow buffer occupied
//   frame_done, dropped      one-cycle pulses: frame finished / load rejected
//   drop_count               saturating count of rejected loads
module packet_framer
    import packet_framer_pkg::*;
#(
    parameter int         PACKET_SIZE = 72,
    parameter bit         BINARY      = 1'b0,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter logic [7:0] TERM_BYTE   = 8'h0D
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [PACKET_SIZE-1:0] packet_in,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   dropped,
    output logic [7:0]             drop_count
);

    localparam int CW = $clog2(PACKET_SIZE / 4 + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(BINARY ? PACKET_SIZE / 8 - 1 : PACKET_SIZE / 4 - 1);
    localparam logic [CW-1:0] CRC_LAST  = CW'(BINARY ? 1 : 3);

    state_e                 state_q, state_d;
    logic [PACKET_SIZE-1:0] active_q, active_d, shadow_q, shadow_d;
    logic                   full_q, full_d, valid_q, valid_d, done_q, done_d, drop_q, drop_d;
    logic [15:0]            crc_q, crc_d, crc_next;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             byte_q, byte_d, drop_cnt_q, drop_cnt_d;
    logic                   xfer, promote, accept;
    logic [3:0]             nib_data, nib_crc;

    crc16_ccitt_byte u_crc (
        .crc_in   (crc_q),
        .data_byte(active_q[PACKET_SIZE-1 -: 8]),
        .crc_out  (crc_next)
    );

    always_comb begin
        xfer       = valid_q & byte_ready;
        promote    = state_q == IDLE && full_q;
        accept     = load && (!full_q || promote);
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        crc_d      = crc_q;
        shadow_d   = accept ? packet_in : shadow_q;
        full_d     = accept || (full_q && !promote);
        drop_d     = load && !accept;
        drop_cnt_d = drop_cnt_q + 8'(drop_d && drop_cnt_q != 8'hFF);
        done_d     = 1'b0;
        if (promote) begin
            state_d  = BINARY ? SYNC : DATA;
            cnt_d    = '0;
            active_d = shadow_q;
            crc_d    = CRC_INIT;
        end else if (xfer) begin
            case (state_q)
                SYNC: state_d = DATA;
                DATA: begin
                    // ASCII consumes a payload byte only once its low-nibble char is taken
                    if (BINARY || cnt_q[0]) begin
                        crc_d    = crc_next;
                        active_d = active_q << 8;
                    end
                    cnt_d   = cnt_q == DATA_LAST ? '0 : cnt_q + CW'(1);
                    state_d = cnt_q == DATA_LAST ? CRC : DATA;
                end
                CRC: begin
                    cnt_d   = cnt_q == CRC_LAST ? '0 : cnt_q + CW'(1);
                    state_d = cnt_q != CRC_LAST ? CRC : BINARY ? IDLE : TERM;
                end
                TERM:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
            done_d = state_d == IDLE;
        end
        // Output byte is registered from the next state, so a new byte follows each transfer directly
        valid_d  = state_d != IDLE && !promote;
        nib_data = cnt_d[0] ? active_d[PACKET_SIZE-5 -: 4] : active_d[PACKET_SIZE-1 -: 4];
        nib_crc  = 4'(crc_d >> {2'd3 - cnt_d[1:0], 2'b00});
        byte_d   = state_d == SYNC ? SYNC_BYTE :
                   state_d == TERM ? TERM_BYTE :
                   state_d == DATA ? (BINARY ? active_d[PACKET_SIZE-1 -: 8] : hex_char(nib_data)) :
                   state_d == CRC  ? (BINARY ? (cnt_d[0] ? crc_d[7:0] : crc_d[15:8]) : hex_char(nib_crc)) :
                   byte_q;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            active_q   <= '0;
            shadow_q   <= '0;
            full_q     <= 1'b0;
            crc_q      <= CRC_INIT;
            byte_q     <= 8'h00;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            full_q     <= full_d;
            crc_q      <= crc_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign busy       = state_q != IDLE || full_q;
    assign frame_done = done_q;
    assign dropped    = drop_q;
    assign drop_count = drop_cnt_q;

endmodule
